// File: rtl/page_tbl_arb_if.sv
// Handshake bundle for the page-table arbiter: control-path writes, VLAN lookups,
// lookup results and debug status.
interface page_tbl_arb_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned VLAN_W = 12
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              lk_valid;
    logic [VLAN_W-1:0] lk_vlan;
    logic              lk_ready;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;

    logic              init_done;
    logic [2:0]        starve_cnt;

    modport master (
        output wr_valid, wr_addr, wr_data, lk_valid, lk_vlan, res_ready,
        input  wr_ready, lk_ready, res_valid, res_data, init_done, starve_cnt
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, lk_valid, lk_vlan, res_ready,
        output wr_ready, lk_ready, res_valid, res_data, init_done, starve_cnt
    );
endinterface

// File: rtl/page_tbl_arb.sv
// Page-table register array shared between control-path writes and VLAN lookups,
// with a write-priority arbiter that bounds lookup starvation.
module page_tbl_arb #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned VLAN_W     = 12,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst_n,
    page_tbl_arb_if.slave bus
);
    localparam int unsigned       DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        STARVE_LIM = 3'(STARVE_MAX);

    typedef enum logic {StInit, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] init_idx_q;
    logic              init_done_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic [2:0]        starve_cnt_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              slot_free;
    logic              lk_grantable;
    logic              grant_lk;
    logic              grant_wr;
    logic [ADDR_W-1:0] lk_idx;

    assign lk_idx = bus.lk_vlan[ADDR_W+3:4];

    // Gating on rst_n keeps both readies low while reset is held, even out of StRun.
    always_comb begin
        run          = rst_n && (state_q == StRun);
        slot_free    = !res_valid_q || bus.res_ready;
        lk_grantable = run && bus.lk_valid && slot_free;
        grant_lk     = lk_grantable && (!bus.wr_valid || (starve_cnt_q == STARVE_LIM));
        grant_wr     = run && bus.wr_valid && !grant_lk;
    end

    assign bus.wr_ready   = grant_wr;
    assign bus.lk_ready   = grant_lk;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.init_done  = init_done_q;
    assign bus.starve_cnt = starve_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StInit;
            init_idx_q   <= '0;
            init_done_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            starve_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    init_idx_q <= init_idx_q + ADDR_W'(1);
                    if (init_idx_q == LAST_IDX) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (grant_lk) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= mem[lk_idx];
                    end else if (res_valid_q && bus.res_ready) begin
                        res_valid_q <= 1'b0;
                    end
                    // Only a grantable lookup losing to a write counts as starvation.
                    if (grant_lk || !lk_grantable) begin
                        starve_cnt_q <= '0;
                    end else if (starve_cnt_q != STARVE_LIM) begin
                        starve_cnt_q <= starve_cnt_q + 3'd1;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == StInit) begin
                mem[init_idx_q] <= '0;
            end else if (grant_wr) begin
                mem[bus.wr_addr] <= bus.wr_data;
            end
        end
    end
endmodule

// File: doc/page_tbl_arb.md
PAGE_TBL_ARB -- requirements
Module: page_tbl_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, page-table index width (depth 2^ADDR_W = 32).
REQ-002 SHALL have parameter DATA_W, default 16, page-table entry width.
REQ-003 SHALL have parameter VLAN_W, default 12, VLAN ID width.
REQ-004 SHALL have parameter STARVE_MAX, default 4, max consecutive cycles a grantable lookup loses to writes.
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have ports wr_valid (input, 1), wr_addr (input, ADDR_W), wr_data (input, DATA_W) and wr_ready (output, 1): control-path write request.
REQ-008 SHALL have ports lk_valid (input, 1), lk_vlan (input, VLAN_W) and lk_ready (output, 1): lookup request from the action-stage VLAN FIFO.
REQ-009 SHALL have ports res_valid (output, 1), res_data (output, DATA_W) and res_ready (input, 1): lookup result.
REQ-010 SHALL have port init_done, output, 1: table clear complete.
REQ-011 SHALL have port starve_cnt, output, 3: current starvation count, for debug.

Function
REQ-012 SHALL hold a 2^ADDR_W x DATA_W register array.
REQ-013 SHALL form the lookup index as lk_vlan[ADDR_W+3:4], i.e. bits [8:4] at defaults.
REQ-014 SHALL run a state machine with states INIT, RUN.
REQ-015 SHALL, in INIT, write zero to entries 0..2^ADDR_W-1 at one entry per cycle, driving wr_ready=0 and lk_ready=0.
REQ-016 SHALL enter RUN after entry 2^ADDR_W-1 is cleared, then set init_done=1 (32 INIT cycles at default).
REQ-017 SHALL, in RUN, define the result slot as free when res_valid==0 or res_ready==1.
REQ-018 SHALL, in RUN, treat a lookup as grantable when lk_valid==1 and the result slot is free.
REQ-019 SHALL, in RUN, arbitrate as follows:
- Write only: grant the write.
- Grantable lookup only: grant the lookup.
- Both: grant the write unless starve_cnt==STARVE_MAX, in which case grant the lookup.
REQ-020 SHALL drive wr_ready and lk_ready combinationally equal to the respective grants, at most one high per cycle.
REQ-021 SHALL, on a granted write, update array[wr_addr] with wr_data at the clock edge.
REQ-022 SHALL, on a granted lookup at cycle T, present array[index] on res_data with res_valid=1 from cycle T+1.
REQ-023 SHALL hold res_valid and res_data stable until res_ready==1 is sampled.
REQ-024 SHALL clear res_valid on acceptance unless a new lookup is granted in the same cycle, giving back-to-back throughput of 1 lookup/cycle.
REQ-025 SHALL increment starve_cnt, saturating at STARVE_MAX, on each cycle a grantable lookup loses to a write.
REQ-026 SHALL zero starve_cnt when a lookup is granted or when no grantable lookup exists.
REQ-027 SHALL return the pre-write value for a lookup of an address written in an earlier cycle only if that lookup was granted before the write (no same-cycle hazard; single grant per cycle).
REQ-028 SHALL not count a lookup blocked by a full result slot as starvation.
REQ-029 SHALL drop nothing: every accepted write updates the array, and every accepted lookup produces exactly one result.

Reset
REQ-030 SHALL, while rst_n==0 at a clock edge, set state=INIT, clear index=0, init_done=0, res_valid=0, res_data=0 and starve_cnt=0.
REQ-031 SHALL, on reset asserted mid-operation, discard any pending result, restart the full clear and return all entries to 0.
REQ-032 SHALL keep wr_ready=0 and lk_ready=0 during reset and INIT.

Verification
REQ-033 SHALL cover: release reset -> init_done rises after 32 cycles; lookup of lk_vlan=12'h0F0 returns 16'h0000.
REQ-034 SHALL cover: write addr 5 = 16'hA5A5, then lookup lk_vlan=12'h050 -> res_valid one cycle after grant, res_data=16'hA5A5.
REQ-035 SHALL cover: wr_valid and lk_valid held high continuously with res_ready=1 -> 4 writes granted, lookup granted on the 5th cycle, starve_cnt 0,1,2,3,4,0.
REQ-036 SHALL cover: res_ready=0 with result pending and lk_valid=1 -> lk_ready=0, res_data stable, starve_cnt stays 0, writes still granted.
REQ-037 SHALL cover: lookups to addrs 1,2,3 on consecutive cycles with res_ready=1 -> three results on consecutive cycles in order.
REQ-038 SHALL cover: reset pulsed while a result is pending -> res_valid=0 next cycle, INIT re-runs, previously written addr 5 reads 0.
